// File: rtl/tile_collision_checker.sv
// Sequential sprite-box vs. solid-tile overlap checker over a row-major tile map.
// One tile is tested per clock, stopping at the first solid tile or at the box's last tile.
module tile_collision_checker #(
    parameter int MAP_ROWS   = 30,
    parameter int MAP_COLS   = 40,
    parameter int TILE_SHIFT = 4,
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int COORD_W    = 10
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic [0:MAP_ROWS-1][0:MAP_COLS-1]   Tile,
    input  logic                                req,
    input  logic [COORD_W-1:0]                  pos_x,
    input  logic [COORD_W-1:0]                  pos_y,
    output logic                                busy,
    output logic                                done,
    output logic                                hit,
    output logic                                oob,
    output logic [4:0]                          hit_row,
    output logic [5:0]                          hit_col
);

    localparam logic [COORD_W:0] MAP_W_PX = (COORD_W+1)'(MAP_COLS << TILE_SHIFT);
    localparam logic [COORD_W:0] MAP_H_PX = (COORD_W+1)'(MAP_ROWS << TILE_SHIFT);
    localparam logic [COORD_W:0] BOX_W_M1 = (COORD_W+1)'(SPR_W - 1);
    localparam logic [COORD_W:0] BOX_H_M1 = (COORD_W+1)'(SPR_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_r;
    logic [COORD_W-1:0]   px_r;
    logic [COORD_W-1:0]   py_r;
    logic [4:0]           row_r;
    logic [5:0]           col_r;
    logic [5:0]           c0_r;
    logic [5:0]           c1_r;
    logic [4:0]           r1_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 hit_r;
    logic                 oob_r;
    logic [4:0]           hit_row_r;
    logic [5:0]           hit_col_r;

    logic [COORD_W:0]     x1_s;
    logic [COORD_W:0]     y1_s;
    logic                 oob_s;
    logic                 tile_s;
    logic                 last_s;

    // Far box corner at one extra bit so a box hanging off the map cannot wrap back inside
    always_comb begin
        x1_s   = {1'b0, px_r} + BOX_W_M1;
        y1_s   = {1'b0, py_r} + BOX_H_M1;
        oob_s  = 1'b0;
        if ((x1_s >= MAP_W_PX) || (y1_s >= MAP_H_PX)) begin
            oob_s = 1'b1;
        end else begin
            oob_s = 1'b0;
        end
        tile_s = Tile[row_r][col_r];
        last_s = (row_r == r1_r) && (col_r == c1_r);
    end

    // Query sequencer: accept, bound check, row-major scan, one-cycle completion pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            px_r      <= '0;
            py_r      <= '0;
            row_r     <= 5'd0;
            col_r     <= 6'd0;
            c0_r      <= 6'd0;
            c1_r      <= 6'd0;
            r1_r      <= 5'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hit_r     <= 1'b0;
            oob_r     <= 1'b0;
            hit_row_r <= 5'd0;
            hit_col_r <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (req) begin
                        px_r      <= pos_x;
                        py_r      <= pos_y;
                        busy_r    <= 1'b1;
                        hit_r     <= 1'b0;
                        oob_r     <= 1'b0;
                        hit_row_r <= 5'd0;
                        hit_col_r <= 6'd0;
                        state_r   <= ST_CALC;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (oob_s) begin
                        oob_r   <= 1'b1;
                        hit_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        row_r   <= 5'(py_r >> TILE_SHIFT);
                        col_r   <= 6'(px_r >> TILE_SHIFT);
                        c0_r    <= 6'(px_r >> TILE_SHIFT);
                        c1_r    <= 6'(x1_s >> TILE_SHIFT);
                        r1_r    <= 5'(y1_s >> TILE_SHIFT);
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (tile_s) begin
                        hit_r     <= 1'b1;
                        hit_row_r <= row_r;
                        hit_col_r <= col_r;
                        state_r   <= ST_DONE;
                    end else if (last_s) begin
                        hit_r     <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (col_r == c1_r) begin
                        col_r     <= c0_r;
                        row_r     <= row_r + 5'd1;
                    end else begin
                        col_r     <= col_r + 6'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign hit     = hit_r;
    assign oob     = oob_r;
    assign hit_row = hit_row_r;
    assign hit_col = hit_col_r;

endmodule

// File: tb/tb_tile_collision_checker.sv
// Randomized and directed checks of tile_collision_checker against a loop-based overlap model.
module tb_tile_collision_checker;

    localparam int ROWS = 30;
    localparam int COLS = 40;
    localparam int SW   = 16;
    localparam int SH   = 16;

    logic                      clk_s;
    logic                      rst_n_s;
    logic [0:ROWS-1][0:COLS-1] tile_map_s;
    logic                      req_s;
    logic [9:0]                pos_x_s;
    logic [9:0]                pos_y_s;
    logic                      busy_s;
    logic                      done_s;
    logic                      hit_s;
    logic                      oob_s;
    logic [4:0]                hit_row_s;
    logic [5:0]                hit_col_s;

    int checks_r;
    int errors_r;

    tile_collision_checker dut (
        .Clk     (clk_s),
        .Reset_n (rst_n_s),
        .Tile    (tile_map_s),
        .req     (req_s),
        .pos_x   (pos_x_s),
        .pos_y   (pos_y_s),
        .busy    (busy_s),
        .done    (done_s),
        .hit     (hit_s),
        .oob     (oob_s),
        .hit_row (hit_row_s),
        .hit_col (hit_col_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference: enumerate covered tiles row-major and report the first solid one
    task automatic model(input int x, input int y, output int eh, output int eo,
                         output int er, output int ec, output int el);
        int x1;
        int y1;
        int n;
        x1 = x + SW - 1;
        y1 = y + SH - 1;
        eh = 0; eo = 0; er = 0; ec = 0;
        if (x1 >= COLS * 16 || y1 >= ROWS * 16) begin
            eh = 1; eo = 1; el = 2;
            return;
        end
        n = 0;
        for (int r = y / 16; r <= y1 / 16; r++) begin
            for (int c = x / 16; c <= x1 / 16; c++) begin
                n++;
                if (tile_map_s[r][c]) begin
                    eh = 1; er = r; ec = c; el = n + 2;
                    return;
                end
            end
        end
        el = n + 2;
    endtask

    // Issue one query, wait for done, compare all results against the model
    task automatic run_query(input string tag, input int x, input int y);
        int eh, eo, er, ec, el;
        int cyc;
        model(x, y, eh, eo, er, ec, el);
        @(negedge clk_s);
        req_s   = 1'b1;
        pos_x_s = 10'(x);
        pos_y_s = 10'(y);
        @(posedge clk_s);
        #1;
        req_s = 1'b0;
        check_eq({tag, "_busy"}, int'(busy_s), 1);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk_s);
            cyc++;
            #1;
            if (done_s) break;
        end
        check_eq({tag, "_lat"}, cyc, el);
        check_eq({tag, "_hit"}, int'(hit_s), eh);
        check_eq({tag, "_oob"}, int'(oob_s), eo);
        check_eq({tag, "_row"}, int'(hit_row_s), er);
        check_eq({tag, "_col"}, int'(hit_col_s), ec);
        @(posedge clk_s);
        #1;
        check_eq({tag, "_pulse"}, int'(done_s), 0);
        check_eq({tag, "_hold"}, int'(hit_s), eh);
    endtask

    initial begin
        int first_done;
        int n_done;
        checks_r   = 0;
        errors_r   = 0;
        rst_n_s    = 1'b0;
        req_s      = 1'b0;
        pos_x_s    = 10'd0;
        pos_y_s    = 10'd0;
        tile_map_s = '0;
        repeat (3) @(posedge clk_s);
        #1;
        check_eq("rst_busy", int'(busy_s), 0);
        check_eq("rst_done", int'(done_s), 0);
        check_eq("rst_hit", int'(hit_s), 0);
        check_eq("rst_rowcol", int'({hit_row_s, hit_col_s}), 0);
        @(negedge clk_s);
        rst_n_s = 1'b1;

        tile_map_s[5][10] = 1'b1;
        run_query("single", 160, 80);
        run_query("quad", 150, 70);
        tile_map_s = '0;
        run_query("zero1", 0, 0);
        run_query("zero4", 8, 8);
        run_query("oobx", 630, 100);
        run_query("ooby", 100, 470);
        run_query("edge", 624, 464);

        // Second req while busy must be dropped
        tile_map_s = '0;
        tile_map_s[4][9] = 1'b1;
        @(negedge clk_s);
        req_s = 1'b1; pos_x_s = 10'd150; pos_y_s = 10'd70;
        @(posedge clk_s); #1; req_s = 1'b0;
        first_done = 0; n_done = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk_s); #1;
            req_s = (i == 1);
            if (done_s) begin
                n_done++;
                if (first_done == 0) first_done = i;
            end
        end
        req_s = 1'b0;
        check_eq("busyreq_cnt", n_done, 1);
        check_eq("busyreq_lat", first_done, 3);
        check_eq("busyreq_row", int'(hit_row_s), 4);
        check_eq("busyreq_col", int'(hit_col_s), 9);

        // Held req re-accepts in the IDLE cycle that shows done
        @(negedge clk_s);
        req_s = 1'b1; pos_x_s = 10'd150; pos_y_s = 10'd70;
        @(posedge clk_s); #1;
        first_done = 0; n_done = 0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk_s); #1;
            if (done_s) begin
                n_done++;
                first_done = i;
            end
        end
        req_s = 1'b0;
        check_eq("b2b_cnt", n_done, 2);
        check_eq("b2b_second", first_done, 7);
        repeat (4) @(posedge clk_s);

        // Reset during scan aborts with no done
        tile_map_s = '0;
        @(negedge clk_s);
        req_s = 1'b1; pos_x_s = 10'd8; pos_y_s = 10'd8;
        @(posedge clk_s); #1; req_s = 1'b0;
        repeat (3) @(posedge clk_s);
        #1;
        rst_n_s = 1'b0;
        #1;
        check_eq("abort_busy", int'(busy_s), 0);
        check_eq("abort_done", int'(done_s), 0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_s); #1;
            if (done_s) n_done++;
        end
        check_eq("abort_nodone", n_done, 0);
        @(negedge clk_s);
        rst_n_s = 1'b1;
        run_query("post_rst", 8, 8);

        for (int k = 0; k < 40; k++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    tile_map_s[r][c] = ($urandom_range(0, 15) == 0);
            run_query("rand", int'($urandom_range(0, 660)), int'($urandom_range(0, 500)));
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/tile_collision_checker.md
Name: tile_collision_checker

Overview:
Reads the 30x40 solid-tile map and answers "does this sprite bounding box overlap any solid tile?" for game logic.
- The map is supplied as the packed array produced by the tile map ROM: row-major, col 0 = MSB = leftmost, 16x16-pixel tiles on a 640x480 screen.
- Accepts one query at a time and scans the covered tiles sequentially, one tile per clock, with early exit on the first solid tile.
- Sits between the sprite/player motion logic and the tile map.

Parameters:
MAP_ROWS, 30, tile rows in map
MAP_COLS, 40, tile columns in map
TILE_SHIFT, 4, log2 of tile size in pixels (16 px)
SPR_W, 16, sprite box width in pixels (1..64)
SPR_H, 16, sprite box height in pixels (1..64)
COORD_W, 10, pixel coordinate width

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
Tile  in  [0:MAP_ROWS-1][0:MAP_COLS-1]  map; Tile[r][c]=1 means solid
req  in  1  query request, sampled only in IDLE
pos_x  in  COORD_W  box left pixel, sampled with req
pos_y  in  COORD_W  box top pixel, sampled with req
busy  out  1  high from the cycle after accept through DONE
done  out  1  one-cycle pulse, results valid
hit  out  1  box overlaps a solid tile or leaves the map
oob  out  1  box extends past the map edge
hit_row  out  5  row of first solid tile found (0 if none/oob)
hit_col  out  6  col of first solid tile found (0 if none/oob)

Behaviour:
- Reset (async, Reset_n=0): state IDLE; busy, done, hit, oob, hit_row, hit_col all 0. Reset mid-query aborts the query; no done is produced.
- IDLE:
  - req=1 latches pos_x/pos_y and moves to CALC.
  - hit, oob, hit_row and hit_col clear on accept.
  - req=0 holds the previous results.
- req while busy: ignored, not queued.
- CALC (1 cycle):
  - x1 = pos_x+SPR_W-1, y1 = pos_y+SPR_H-1, computed at COORD_W+1 bits (no wrap).
  - If x1 >= MAP_COLS<<TILE_SHIFT or y1 >= MAP_ROWS<<TILE_SHIFT: oob=1, hit=1, go to DONE.
  - Else c0=pos_x>>TILE_SHIFT, c1=x1>>TILE_SHIFT, r0=pos_y>>TILE_SHIFT, r1=y1>>TILE_SHIFT; cursor (r,c)=(r0,c0); go to SCAN.
- SCAN (one tile per cycle, row-major):
  - Test Tile[r][c]. If 1: hit=1, hit_row=r, hit_col=c, go to DONE.
  - Else if (r,c)=(r1,c1): hit=0, go to DONE.
  - Else if c=c1: c=c0, r=r+1.
  - Else c=c+1.
- DONE (1 cycle): done=1, busy=1; next state IDLE. Results persist until the next accepted req.
- Latency, counted from the accepting edge to the edge where done is registered high:
  - oob: 2 cycles.
  - First solid tile at scan position i (1-based): i+2 cycles.
  - No hit over N tiles: N+2 cycles.
- Tile may change during a scan; each tile is sampled in the cycle it is tested.
- Back-to-back: req held high re-accepts on the cycle after DONE (in IDLE).

Test Plan:
- Map all 0 except Tile[5][10]=1; req with (160,80) -> done 3 cycles after accept, hit=1, oob=0, hit_row=5, hit_col=10.
- Same map; req with (150,70), covering rows 4-5 and cols 9-10 -> scan order (4,9),(4,10),(5,9),(5,10); done 6 cycles after accept, hit=1, row=5, col=10.
- All-zero map; req with (0,0) -> done at 3 cycles, hit=0, oob=0, row=col=0. Then (8,8) -> 4 tiles, done at 6 cycles, hit=0.
- req with (630,100) (x1=645) -> done at 2 cycles, hit=1, oob=1, row=col=0. Also (100,470) -> same result.
- Full map with Tile[4][9]=1; accept (150,70), then pulse req again while busy -> only one done pulse, hit_row=4, hit_col=9 at 3 cycles. Hold req high -> second query accepted the cycle after DONE.
- Drop Reset_n during SCAN -> outputs 0 immediately, no done. After release, a fresh query behaves normally.
